dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter sharing the single-port data memory between the core load/store path (port 0) and a secondary requester such as a debug or DMA master (port 1). It accepts requests with a req/gnt handshake, registers the winning transaction, and drives the memory for exactly one access cycle. It returns a one-cycle completion pulse with registered read data to the owning port. It sits between the core's LSU signals (ALU result address, rs2 write data, decoder mem_req/mem_we/mem_size) and the data memory, and exports a stall for the PC/register-file write enable.

## Interface
- No parameters; data and address width fixed at 32, size field 3 bits in decoder encoding (0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU).
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- p0_req, p1_req  in  1  request valid; held with payload stable until gnt
- p0_we, p1_we  in  1  1 = store, 0 = load
- p0_size, p1_size  in  3  access size, passed through unmodified
- p0_addr, p1_addr  in  32  byte address
- p0_wdata, p1_wdata  in  32  store data
- p0_gnt, p1_gnt  out  1  combinational; request accepted this cycle
- p0_rvalid, p1_rvalid  out  1  registered one-cycle completion pulse (loads and stores)
- p0_rdata, p1_rdata  out  32  registered load data, valid with rvalid
- stall_o  out  1  p0_req & ~p0_gnt, or port 0 access outstanding (gnt seen, rvalid not yet)
- mem_we  out  1  memory write enable
- mem_i  out  4  {access strobe, size}, matching the data memory I port
- mem_a  out  32  memory address
- mem_wd  out  32  memory write data
- mem_rd  in  32  memory read data, combinational from mem_a

## Operation
- FSM: IDLE, ACCESS. Reset → IDLE.
- Accept condition: in IDLE or ACCESS, at least one req high → exactly one gnt high; payload and owner latched at that edge; next state ACCESS. No req → next state IDLE.
- ACCESS: mem_i = {1, latched size}, mem_a/mem_wd from latch, mem_we = latched we. In IDLE, mem_we = 0, mem_i = 0, mem_a/mem_wd hold the last value.
- End of ACCESS edge: store commits in memory; mem_rd captured into the owner's rdata register (stores leave rdata unchanged); owner's rvalid set for the next cycle only.
- Arbitration with both req high: grant the port not granted last (last_owner register, reset to 1 so port 0 wins first). Single requester always wins.
- gnt never asserts for a port whose req is low; at most one gnt per cycle.
- Payload not latched unless gnt; a requester dropping req before gnt is legal, and nothing happens.

## Timing
- Grant in cycle N → memory access in cycle N+1 → rvalid/rdata in cycle N+2. Load latency 2 cycles from gnt.
- Back-to-back: a new grant may occur in ACCESS cycle N+1, giving 1 access per cycle sustained.
- Alternating: port 0 and port 1 both continuously requesting → grants alternate every cycle.
- Reset values: all gnt/rvalid 0, rdata 0, mem_we 0, mem_i 0, mem_a 0, mem_wd 0, stall_o = p0_req.
- Reset mid-ACCESS: mem_we and mem_i drop immediately (async); the in-flight store does not commit; no rvalid is produced; the latch is cleared.
- rvalid for access K and gnt for access K+1 may occur in the same cycle on the same port.

## Configuration
- DMEM_ARB_ROUND_ROBIN_EN defined: round-robin as above.
- Undefined: fixed priority, port 0 always wins on contention. last_owner is not implemented. Port 1 may starve while port 0 requests every cycle.

## Test plan
- Single load port 0: mem holds 0xDEADBEEF at 0x40, p0 req we=0 size=2 addr=0x40 → p0_gnt same cycle, mem_i=4'b1010 next cycle, p0_rvalid with rdata 0xDEADBEEF 2 cycles after gnt.
- Port 1 store then port 0 load of 0x80, wdata 0x12345678 → p0 reads 0x12345678; p1_rvalid pulses once, p1_rdata unchanged.
- Both req held 6 cycles (RR build) → grant order p0, p1, p0, p1, p0, p1, one memory access per cycle. Fixed build → six p0 grants, stall_o=0, p1_gnt never.
- Port 1 owning memory while p0 requests (fixed build, p0 arrives while p1 in ACCESS) → p0_gnt at next accept, stall_o high until p0_rvalid.
- rst asserted during a store ACCESS to 0x10 (old 0xAAAA0000) → mem_we falls asynchronously, 0x10 still reads 0xAAAA0000, no rvalid, FSM IDLE.
- Request dropped before grant under contention → no latch, no mem_i strobe, no rvalid for that port.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the core LSU
// (port 0) and a secondary master such as debug or DMA (port 1).
//
// A request is accepted with a combinational gnt. The winning payload is
// registered and drives the memory for exactly one ACCESS cycle. The owner
// then sees a one-cycle rvalid pulse, plus registered rdata for loads.
// A new grant can occur during ACCESS, so the memory sustains one access
// per cycle.
//
// Ports:
//   clk, rst                   clock; asynchronous active-high reset
//   pN_req/we/size/addr/wdata  request payload from port N (N = 0, 1)
//   pN_gnt                     combinational accept
//   pN_rvalid, pN_rdata        registered completion pulse and load data
//   stall_o                    holds the core while its access is pending
//   mem_we, mem_i, mem_a,      data memory drive; mem_i = {strobe, size}
//   mem_wd
//   mem_rd                     memory read data, combinational from mem_a
//
// Build option:
//   DMEM_ARB_ROUND_ROBIN_EN    defined: alternate grants on contention.
//                              undefined: port 0 has fixed priority.
module dmem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [2:0]  p0_size,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [2:0]  p1_size,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p0_gnt,
  output logic        p1_gnt,
  output logic        p0_rvalid,
  output logic        p1_rvalid,
  output logic [31:0] p0_rdata,
  output logic [31:0] p1_rdata,
  output logic        stall_o,
  output logic        mem_we,
  output logic [3:0]  mem_i,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic        sel;        // 1: port 1 wins this cycle
  logic        lat_we;
  logic        lat_owner;  // 0: port 0, 1: port 1
  logic [2:0]  lat_size;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        p0_busy;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // Owner of the most recent grant. It resets to 1 so that port 0 wins
  // the first contention.
  logic last_owner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_owner <= 1'b1;
    else if (accept) last_owner <= sel;
  end

  // Under contention, grant the port that was not granted last.
  assign sel = p1_req & (~p0_req | ~last_owner);
`else
  // Fixed priority: port 1 wins only when port 0 is not requesting.
  assign sel = p1_req & ~p0_req;
`endif

  // Grants are masked while reset is high, so that no request is
  // acknowledged that will never be latched.
  assign accept = ~rst & (p0_req | p1_req);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    p0_gnt    = 1'b0;
    p1_gnt    = 1'b0;
    mem_we    = 1'b0;
    mem_i     = 4'b0000;
    // Accepts happen in IDLE and in ACCESS alike. Only the memory drive
    // depends on the state.
    if (accept) begin
      state_nxt = ACCESS;
      p0_gnt    = ~sel;
      p1_gnt    = sel;
    end
    if (state == ACCESS) begin
      mem_we = lat_we;
      mem_i  = {1'b1, lat_size};
    end
  end

  // Payload latch. It is written only on a grant, so a request that is
  // dropped before its grant leaves no trace. Address and data keep their
  // last value through IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_we    <= 1'b0;
      lat_owner <= 1'b0;
      lat_size  <= 3'd0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
    end else if (accept) begin
      lat_owner <= sel;
      lat_we    <= sel ? p1_we    : p0_we;
      lat_size  <= sel ? p1_size  : p0_size;
      lat_addr  <= sel ? p1_addr  : p0_addr;
      lat_wdata <= sel ? p1_wdata : p0_wdata;
    end
  end

  assign mem_a  = lat_addr;
  assign mem_wd = lat_wdata;

  // Completion. The edge that ends ACCESS returns rvalid to the owner.
  // Loads also capture mem_rd; stores leave rdata untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= 32'd0;
      p1_rdata  <= 32'd0;
    end else begin
      p0_rvalid <= (state == ACCESS) & ~lat_owner;
      p1_rvalid <= (state == ACCESS) &  lat_owner;
      if (state == ACCESS && !lat_we) begin
        if (lat_owner) p1_rdata <= mem_rd;
        else           p0_rdata <= mem_rd;
      end
    end
  end

  // The core stalls while its request waits for a grant, or while its
  // access is in flight. A fresh port 0 grant releases the stall even when
  // an earlier port 0 access is still in ACCESS. The LSU pipeline keeps
  // moving, and rvalid still marks each completion.
  assign p0_busy = (state == ACCESS) & ~lat_owner;
  assign stall_o = (p0_req | p0_busy) & ~p0_gnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter. A small word-addressed memory model
// sits behind the memory port. Contention expectations follow the build
// option DMEM_ARB_ROUND_ROBIN_EN.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [2:0]  p0_size, p1_size;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, stall_o, mem_we;
  logic [31:0] p0_rdata, p1_rdata, mem_a, mem_wd, mem_rd;
  logic [3:0]  mem_i;

  logic [31:0] mem [0:255];
  int n_tests = 0;
  int n_fail  = 0;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata), .stall_o(stall_o),
    .mem_we(mem_we), .mem_i(mem_i), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_a[9:2]];
  always @(posedge clk) if (mem_we && mem_i[3]) mem[mem_a[9:2]] <= mem_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive0(input logic r, input logic we, input logic [31:0] a, input logic [31:0] d);
    p0_req = r; p0_we = we; p0_size = 3'd2; p0_addr = a; p0_wdata = d;
  endtask

  task automatic drive1(input logic r, input logic we, input logic [31:0] a, input logic [31:0] d);
    p1_req = r; p1_we = we; p1_size = 3'd2; p1_addr = a; p1_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[8'h10] = 32'hDEADBEEF;   // byte address 0x40
    mem[8'h04] = 32'hAAAA0000;   // byte address 0x10
    rst = 1'b1;
    drive0(1'b1, 1'b0, 32'h40, 32'd0);
    drive1(1'b0, 1'b0, 32'h0, 32'd0);
    tick(); tick();

    // Reset state, with port 0 requesting during reset.
    chk("rst_p0_gnt", p0_gnt, 0);
    chk("rst_p1_gnt", p1_gnt, 0);
    chk("rst_rvalid", {p0_rvalid, p1_rvalid}, 0);
    chk("rst_rdata0", p0_rdata, 0);
    chk("rst_rdata1", p1_rdata, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_i", mem_i, 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_wd", mem_wd, 0);
    chk("rst_stall", stall_o, 1);

    // Single load from port 0.
    rst = 1'b0; #1;
    chk("t1_gnt0", p0_gnt, 1);
    chk("t1_gnt1", p1_gnt, 0);
    chk("t1_stall", stall_o, 0);
    tick(); drive0(1'b0, 1'b0, 32'h40, 32'd0); #1;
    chk("t1_mem_i", mem_i, 4'b1010);
    chk("t1_mem_a", mem_a, 32'h40);
    chk("t1_mem_we", mem_we, 0);
    chk("t1_stall_busy", stall_o, 1);
    chk("t1_early_rv", p0_rvalid, 0);
    tick(); #1;
    chk("t1_rvalid", p0_rvalid, 1);
    chk("t1_rdata", p0_rdata, 32'hDEADBEEF);
    chk("t1_mem_i_idle", mem_i, 0);
    chk("t1_stall_done", stall_o, 0);
    tick(); #1;
    chk("t1_rvalid_pulse", p0_rvalid, 0);

    // Port 1 store to 0x80, then port 0 load of 0x80 granted during ACCESS.
    drive1(1'b1, 1'b1, 32'h80, 32'h12345678); #1;
    chk("t2_gnt1", p1_gnt, 1);
    tick(); drive1(1'b0, 1'b0, 32'h0, 32'd0); drive0(1'b1, 1'b0, 32'h80, 32'd0); #1;
    chk("t2_mem_we", mem_we, 1);
    chk("t2_mem_wd", mem_wd, 32'h12345678);
    chk("t2_gnt0_b2b", p0_gnt, 1);
    tick(); drive0(1'b0, 1'b0, 32'h0, 32'd0); #1;
    chk("t2_p1_rvalid", p1_rvalid, 1);
    chk("t2_p1_rdata_keep", p1_rdata, 0);
    chk("t2_mem_a", mem_a, 32'h80);
    tick(); #1;
    chk("t2_p0_rvalid", p0_rvalid, 1);
    chk("t2_p0_rdata", p0_rdata, 32'h12345678);
    chk("t2_p1_rvalid_once", p1_rvalid, 0);

    // Port 1 load of 0x10, which also leaves port 1 as the last owner.
    drive1(1'b1, 1'b0, 32'h10, 32'd0); #1;
    chk("t2b_gnt1", p1_gnt, 1);
    tick(); drive1(1'b0, 1'b0, 32'h0, 32'd0);
    tick(); #1;
    chk("t2b_p1_rdata", p1_rdata, 32'hAAAA0000);
    tick();

    // Both ports requesting for six cycles.
    drive0(1'b1, 1'b0, 32'h40, 32'd0);
    drive1(1'b1, 1'b0, 32'h80, 32'd0);
    for (int i = 0; i < 6; i++) begin
      #1;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      chk("t3_gnt0", p0_gnt, (i % 2 == 0));
      chk("t3_gnt1", p1_gnt, (i % 2 == 1));
      chk("t3_stall", stall_o, (i % 2 == 1));
      if (i >= 2) chk("t3_rvalid0", p0_rvalid, (i % 2 == 0));
      if (i >= 2) chk("t3_rvalid1", p1_rvalid, (i % 2 == 1));
`else
      chk("t3_gnt0", p0_gnt, 1);
      chk("t3_gnt1", p1_gnt, 0);
      chk("t3_stall", stall_o, 0);
      if (i >= 2) chk("t3_rvalid0", p0_rvalid, 1);
`endif
      if (i >= 1) chk("t3_mem_i", mem_i, 4'b1010);
      tick();
    end
    drive0(1'b0, 1'b0, 32'h0, 32'd0);
    drive1(1'b0, 1'b0, 32'h0, 32'd0);
    tick(); tick(); tick();

    // Contention where port 1 drops its store request after losing.
    drive0(1'b1, 1'b0, 32'h40, 32'd0);
    drive1(1'b1, 1'b1, 32'h10, 32'h55555555); #1;
    chk("t5_gnt0", p0_gnt, 1);
    chk("t5_gnt1", p1_gnt, 0);
    tick(); drive0(1'b0, 1'b0, 32'h0, 32'd0); drive1(1'b0, 1'b0, 32'h0, 32'd0); #1;
    chk("t5_mem_a", mem_a, 32'h40);
    chk("t5_mem_we", mem_we, 0);
    chk("t5_gnt1_late", p1_gnt, 0);
    tick(); #1;
    chk("t5_p0_rvalid", p0_rvalid, 1);
    chk("t5_p1_rvalid", p1_rvalid, 0);
    chk("t5_mem_i", mem_i, 0);
    tick(); #1;
    chk("t5_p1_rvalid2", p1_rvalid, 0);
    chk("t5_mem_untouched", mem[8'h04], 32'hAAAA0000);

    // Port 1 owns the memory when the port 0 request arrives.
    drive1(1'b1, 1'b0, 32'h80, 32'd0); #1;
    chk("t4_gnt1", p1_gnt, 1);
    tick(); drive1(1'b0, 1'b0, 32'h0, 32'd0); drive0(1'b1, 1'b0, 32'h40, 32'd0); #1;
    chk("t4_gnt0", p0_gnt, 1);
    chk("t4_stall_gnt", stall_o, 0);
    chk("t4_mem_a", mem_a, 32'h80);
    tick(); drive0(1'b0, 1'b0, 32'h0, 32'd0); #1;
    chk("t4_stall_busy", stall_o, 1);
    chk("t4_p1_rvalid", p1_rvalid, 1);
    chk("t4_p1_rdata", p1_rdata, 32'h12345678);
    tick(); #1;
    chk("t4_p0_rvalid", p0_rvalid, 1);
    chk("t4_p0_rdata", p0_rdata, 32'hDEADBEEF);
    chk("t4_stall_done", stall_o, 0);
    tick();

    // Reset asserted in the middle of a store ACCESS.
    drive1(1'b1, 1'b1, 32'h10, 32'h12121212); #1;
    chk("t6_gnt1", p1_gnt, 1);
    tick(); drive1(1'b0, 1'b0, 32'h0, 32'd0); #1;
    chk("t6_mem_we_pre", mem_we, 1);
    #2 rst = 1'b1; #1;
    chk("t6_mem_we_async", mem_we, 0);
    chk("t6_mem_i_async", mem_i, 0);
    tick(); #1;
    chk("t6_no_commit", mem[8'h04], 32'hAAAA0000);
    chk("t6_no_rvalid", p1_rvalid, 0);
    chk("t6_latch_clr", mem_a, 0);
    rst = 1'b0;
    tick(); #1;
    chk("t6_idle", mem_i, 0);
    drive0(1'b1, 1'b0, 32'h10, 32'd0); #1;
    chk("t6_gnt0", p0_gnt, 1);
    tick(); drive0(1'b0, 1'b0, 32'h0, 32'd0);
    tick(); #1;
    chk("t6_readback", p0_rdata, 32'hAAAA0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
